// File: rtl/arc_mem_arbiter.sv
// Arbitrates the ARC fetch and load/store ports onto the single-port main_memory.
// Every access walks Idle -> Issue -> Capture -> Ack, so the latency is fixed
// and at most one access completes every four cycles.
module arc_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PROTECT_BASE = 2048,
  parameter bit          RR_EN        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ProtBase = ADDR_W'(PROTECT_BASE);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StAck} state_e;

  state_e            state_q, state_d;
  logic              grant_data_q, grant_data_d;  // 1: data port owns the current access
  logic              last_data_q, last_data_d;    // 1: previous completed access was data
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;

  logic pick_data;
  logic store_blocked;

  // Data wins if alone, if round-robin is off, or if fetch had the last turn.
  assign pick_data     = d_req && (!if_req || !RR_EN || !last_data_q);
  assign store_blocked = d_wr && (d_addr < ProtBase);

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d       = state_q;
    grant_data_d  = grant_data_q;
    last_data_d   = last_data_q;
    wr_d          = wr_q;
    err_d         = err_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    d_err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          grant_data_d = pick_data;
          if (pick_data) begin
            mem_addr_d    = d_addr;
            mem_data_in_d = d_wdata;
            wr_d          = d_wr;
            err_d         = store_blocked;
            mem_rd_d      = !d_wr;
            mem_wr_d      = d_wr && !store_blocked;
          end else begin
            mem_addr_d = if_addr;
            wr_d       = 1'b0;
            err_d      = 1'b0;
            mem_rd_d   = 1'b1;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Memory samples rd/wr on this edge; the strobes drop by default.
        state_d = StCapture;
      end
      StCapture: begin
        if (!wr_q) begin
          if (grant_data_q) begin
            d_rdata_d = mem_data_out;
          end else begin
            if_rdata_d = mem_data_out;
          end
        end
        if (grant_data_q) begin
          d_ack_d = 1'b1;
          d_err_d = err_q;
        end else begin
          if_ack_d = 1'b1;
        end
        state_d = StAck;
      end
      StAck: begin
        last_data_d = grant_data_q;
        err_d       = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_data_q  <= 1'b0;
      last_data_q   <= 1'b0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      d_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_data_q  <= grant_data_d;
      last_data_q   <= last_data_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      d_err_q       <= d_err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign d_err       = d_err_q;
  assign busy        = (state_q != StIdle);

endmodule
